// File: rtl/count_checker_pkg.sv
// Shared types and helpers for the count_checker slice.
package count_checker_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CHECK,
        DONE
    } state_t;

    // Saturating increment for counters up to 32 bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/count_checker_sat_counter.sv
// Clearable saturating statistics counter used for samples, mismatches and wraps.
module sat_counter
    import count_checker_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= CNT_W'(sat_inc(32'(count), CNT_W));
        end
    end

endmodule

// File: rtl/count_checker.sv
// Checks a free-running counter bus over a programmable window and reports one verdict.
// Optional first-mismatch capture ports are enabled by defining COUNT_CHECKER_TRACE_EN.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] window,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] mismatches,
    output logic [CNT_W-1:0] wraps
`ifdef COUNT_CHECKER_TRACE_EN
    ,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
    output logic [CNT_W-1:0] first_idx
`endif
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] expected, prev_in, count_inc;
    logic [CNT_W-1:0] remaining;
    logic             pass_q, clr_stats, do_cmp, mismatch, inc_mis, inc_wrap, verdict;

    assign count_inc = count_in + WIDTH'(1);
    assign mismatch  = (count_in != expected);
    assign inc_mis   = do_cmp && mismatch;
    // A wrap only counts when the 0 was actually the predicted value.
    assign inc_wrap  = do_cmp && !mismatch && (prev_in == '1) && (count_in == '0);
    assign verdict   = (mismatches == '0) && (samples != '0);
    assign pass      = done ? verdict : pass_q;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_stats = 1'b0;
        do_cmp    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SYNC;
                    clr_stats = 1'b1;
                end
            end
            SYNC: begin
                busy      = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (!count_rst) begin
                    do_cmp = 1'b1;
                    if (remaining == CNT_W'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            expected  <= '0;
            prev_in   <= '0;
            remaining <= '0;
            pass_q    <= 1'b0;
        end else begin
            prev_in <= count_in;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= (window == '0) ? CNT_W'(1) : window;
                        pass_q    <= 1'b0;
                    end
                end
                SYNC: expected <= count_rst ? '0 : count_inc;
                CHECK: begin
                    if (count_rst) begin
                        expected <= '0;
                    end else begin
                        expected  <= count_inc;
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                DONE: pass_q <= verdict;
                default: ;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_samples (
        .clk(clk), .async_rst_n(async_rst_n), .clear(clr_stats), .inc(do_cmp), .count(samples)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mismatches (
        .clk(clk), .async_rst_n(async_rst_n), .clear(clr_stats), .inc(inc_mis), .count(mismatches)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wraps (
        .clk(clk), .async_rst_n(async_rst_n), .clear(clr_stats), .inc(inc_wrap), .count(wraps)
    );

`ifdef COUNT_CHECKER_TRACE_EN
    logic captured;

    // first_idx is the zero-based sample index of the first failing compare.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            captured  <= 1'b0;
            first_exp <= '0;
            first_act <= '0;
            first_idx <= '0;
        end else if (clr_stats) begin
            captured  <= 1'b0;
            first_exp <= '0;
            first_act <= '0;
            first_idx <= '0;
        end else if (inc_mis && !captured) begin
            captured  <= 1'b1;
            first_exp <= expected;
            first_act <= count_in;
            first_idx <= samples;
        end
    end
`endif

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: directed vector table plus randomized runs vs a queue-based model.
module tb_count_checker;

    localparam int W = 8;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         async_rst_n = 1'b0;
    logic [W-1:0] count_in = '0;
    logic         count_rst = 1'b0;
    logic         start = 1'b0;
    logic [C-1:0] window = '0;
    logic         busy, done, pass;
    logic [C-1:0] samples, mismatches, wraps;
`ifdef COUNT_CHECKER_TRACE_EN
    logic [W-1:0] first_exp, first_act;
    logic [C-1:0] first_idx;
`endif

    always #5 clk = ~clk;

    count_checker #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .count_in(count_in), .count_rst(count_rst),
        .start(start), .window(window), .busy(busy), .done(done), .pass(pass),
        .samples(samples), .mismatches(mismatches), .wraps(wraps)
`ifdef COUNT_CHECKER_TRACE_EN
        , .first_exp(first_exp), .first_act(first_act), .first_idx(first_idx)
`endif
    );

    typedef struct {
        int window;
        int start_val;
        int skip_at;
        int rst_at;
        int rst_len;
        int extra_k;
        int start_in_done;
        int samples;
        int mis;
        int wraps;
        int pass;
        int lat;
        int fexp;
        int fact;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_vec  = -1;
    int stim_v[$];
    int stim_r[$];
    vec_t tbl[7];
    vec_t rv;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0d expected %0d", name, cur_vec, act, exp);
        end
    endtask

    // Counter stimulus from cycle 0 (the start cycle): optional single skip, reset hold, random glitches.
    task automatic build_stim(input int start_val, input int skip_at, input int rst_at,
                              input int rst_len, input int glitch_pct, input int len);
        int v = start_val;
        int val;
        bit skipped = 0;
        stim_v.delete();
        stim_r.delete();
        for (int k = 0; k < len; k++) begin
            if (rst_len > 0 && k >= rst_at && k < rst_at + rst_len) begin
                stim_v.push_back(0);
                stim_r.push_back(1);
                v = 0;
            end else begin
                val = v;
                if (glitch_pct > 0 && $urandom_range(99) < glitch_pct) val = $urandom_range(255);
                stim_v.push_back(val);
                stim_r.push_back(0);
                if (!skipped && val == skip_at) begin
                    v = (val + 2) % 256;
                    skipped = 1;
                end else begin
                    v = (val + 1) % 256;
                end
            end
        end
    endtask

    // Reference: walk the recorded bus, predicting each value from the previous one.
    task automatic model(input int win, output vec_t r);
        int left;
        int pred;
        r = '{default: 0};
        r.window = win;
        r.extra_k = -1;
        left = (win == 0) ? 1 : win;
        pred = stim_r[1] ? 0 : (stim_v[1] + 1) % 256;
        r.lat = -1;
        for (int k = 2; k < stim_v.size(); k++) begin
            if (stim_r[k] != 0) begin
                pred = 0;
            end else begin
                r.samples++;
                if (stim_v[k] != pred) begin
                    if (r.mis == 0) begin
                        r.fexp = pred;
                        r.fact = stim_v[k];
                    end
                    r.mis++;
                end else if (stim_v[k-1] == 255 && stim_v[k] == 0) begin
                    r.wraps++;
                end
                pred = (stim_v[k] + 1) % 256;
                left--;
                if (left == 0) begin
                    r.lat = k + 1;
                    break;
                end
            end
        end
        r.pass = (r.mis == 0 && r.samples > 0) ? 1 : 0;
    endtask

    task automatic run_vec(input vec_t v);
        int done_cnt = 0;
        int done_at = -1;
        int pass_at_done = -1;
        for (int k = 0; k < stim_v.size(); k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_at = k;
                pass_at_done = int'(pass);
            end
            if (k == 1) chk("busy_after_start", int'(busy), 1);
            count_in  = W'(stim_v[k]);
            count_rst = stim_r[k][0];
            window    = C'(v.window);
            start     = (k == 0) || (k == v.extra_k) || (v.start_in_done != 0 && done);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_latency", done_at, v.lat);
        chk("done_pulses", done_cnt, 1);
        chk("pass_at_done", pass_at_done, v.pass);
        chk("samples", int'(samples), v.samples);
        chk("mismatches", int'(mismatches), v.mis);
        chk("wraps", int'(wraps), v.wraps);
        chk("pass_held", int'(pass), v.pass);
        chk("busy_idle", int'(busy), 0);
`ifdef COUNT_CHECKER_TRACE_EN
        chk("first_exp", int'(first_exp), v.fexp);
        chk("first_act", int'(first_act), v.fact);
`endif
    endtask

    initial begin
        int done_seen;
        //           win st  skip rst_at len xk sid smp mis wr pass lat fexp fact
        tbl[0] = '{300,   0,  -1,  -1, 0, -1, 0, 300, 0, 1, 1, 302,  0,  0};
        tbl[1] = '{ 20,  30,  41,  -1, 0, -1, 0,  20, 1, 0, 0,  22, 42, 43};
        tbl[2] = '{ 10, 100,  -1,   5, 5, -1, 0,  10, 0, 0, 1,  17,  0,  0};
        tbl[3] = '{  0,   7,  -1,  -1, 0, -1, 0,   1, 0, 0, 1,   3,  0,  0};
        tbl[4] = '{  8,  20,  -1,  -1, 0,  5, 1,   8, 0, 0, 1,  10,  0,  0};
        tbl[5] = '{ 12, 250,  -1,  -1, 0, -1, 0,  12, 0, 1, 1,  14,  0,  0};
        tbl[6] = '{ 10, 250, 255,  -1, 0, -1, 0,  10, 1, 0, 0,  12,  0,  1};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_samples", int'(samples), 0);
        chk("rst_mismatches", int'(mismatches), 0);
        chk("rst_wraps", int'(wraps), 0);
        async_rst_n = 1'b1;

        // Abort a run mid-CHECK with the asynchronous reset.
        build_stim(0, -1, -1, 0, 0, 60);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            count_in = W'(stim_v[k]);
            count_rst = 1'b0;
            window = C'(40);
            start = (k == 0);
        end
        @(negedge clk);
        start = 1'b0;
        chk("midrun_samples", int'(samples), 8);
        chk("midrun_busy", int'(busy), 1);
        #2 async_rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_samples", int'(samples), 0);
        chk("abort_done", int'(done), 0);
`ifdef COUNT_CHECKER_TRACE_EN
        chk("abort_first_exp", int'(first_exp), 0);
`endif
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        async_rst_n = 1'b1;
        chk("abort_no_done", done_seen, 0);

        for (int i = 0; i < 7; i++) begin
            cur_vec = i;
            build_stim(tbl[i].start_val, tbl[i].skip_at, tbl[i].rst_at, tbl[i].rst_len, 0,
                       tbl[i].window + tbl[i].rst_len + 8);
            run_vec(tbl[i]);
        end

        for (int i = 0; i < 8; i++) begin
            int win, sv, rat, rlen;
            cur_vec = 100 + i;
            win  = $urandom_range(60, 1);
            sv   = $urandom_range(255);
            rat  = (i % 3 == 0) ? $urandom_range(10, 3) : -1;
            rlen = (i % 3 == 0) ? $urandom_range(6, 1) : 0;
            build_stim(sv, -1, rat, rlen, (i % 2 != 0) ? 6 : 0, win + rlen + 8);
            model(win, rv);
            rv.start_in_done = i % 2;
            rv.extra_k = (i % 4 == 1) ? 3 : -1;
            run_vec(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
